cpu2core_cpu0_dct_capture_ctrl: RTL
===================================

// Module: cpu2core_cpu0_dct_capture_ctrl
// PURPOSE
//  Sequences capture of the cpu0 OCI debug-control-trace (DCT) buffer: packs 2-bit trace
//  symbols into a 30-bit word (15 slots), hands full or flushed words to the trace memory
//  writer over valid/ready, and drives the end-of-test flush and test_ending/test_has_ended
//  status consumed by the OCI test bench. Sits between the OCI trace source and trace RAM.
// PARAMETERS
//  SYM_W    2   bits per trace symbol
//  SLOTS    15  symbols per word; BUF_W = SYM_W*SLOTS = 30
//  CNT_W    4   width of slot counters (holds 0..SLOTS)
//  DROP_W   8   width of saturating drop counter
// PORTS
//  clk             in   1      single clock; all state changes on rising edge
//  reset_n         in   1      reset, synchronous, active-low
//  trace_en        in   1      1 = accept symbols (IDLE->CAPTURE)
//  sym_valid       in   1      symbol strobe, one symbol per cycle max
//  sym_data        in   SYM_W  trace symbol
//  flush_req       in   1      pulse: emit partial word
//  test_end_req    in   1      pulse: final flush, then end
//  out_valid       out  1      word available to trace writer
//  out_ready       in   1      trace writer accepts word when valid&ready
//  out_data        out  BUF_W  packed word, unused slots zero
//  out_count       out  CNT_W  symbols in out_data (1..15)
//  dct_buffer      out  BUF_W  live accumulating buffer
//  dct_count       out  CNT_W  symbols in dct_buffer (0..15)
//  test_ending     out  1      high in ENDING
//  test_has_ended  out  1      high in ENDED, sticky until reset
//  overflow        out  1      sticky: at least one symbol dropped
//  drop_count      out  DROP_W dropped symbols, saturates at 255
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): all outputs 0, state IDLE, flush_pend 0, hold empty; any
//    pending/partial word is discarded.
//  - Packing: symbol accepted into slot k=dct_count at bits [2k+1:2k]; dct_count+1; visible
//    next cycle. Accept = sym_valid & state==CAPTURE & (dct_count<15 | transfer this edge).
//  - hold_free = !out_valid | out_ready. Transfer (buffer->hold, buffer/count cleared) on an
//    edge where hold_free & ((dct_count==15) | (flush_pend & dct_count>0)).
//  - Same-edge transfer+accept: new symbol lands in slot 0, dct_count becomes 1.
//  - Latency: 15th symbol at cycle t -> dct_count=15 at t+1 -> out_valid at t+2 if hold free.
//  - Full stall: dct_count==15 and no transfer -> symbol dropped, overflow<=1, drop_count+1
//    (saturating). Symbols in IDLE/ENDING/ENDED are ignored, not counted as drops.
//  - flush_req sets flush_pend; cleared on transfer, or immediately if dct_count==0 (no word
//    emitted for an empty buffer). Symbol accepted in the flush_req cycle is included.
//  - out_valid holds with stable out_data/out_count until out_ready; deasserts after
//    handshake unless a new transfer occurs on the same edge (back-to-back words allowed).
//  - FSM: IDLE -trace_en-> CAPTURE; CAPTURE -!trace_en-> IDLE (buffer retained);
//    IDLE|CAPTURE -test_end_req-> ENDING (sets flush_pend); ENDING -> ENDED when
//    dct_count==0 & !flush_pend & !out_valid. ENDED terminal until reset.
//  - test_end_req has priority over trace_en in the same cycle; repeated test_end_req in
//    ENDING/ENDED ignored; flush_req in ENDED ignored.
// STRUCTURE
//  - Package cpu2core_cpu0_dct_pkg: state enum {IDLE,CAPTURE,ENDING,ENDED}, SYM_W/SLOTS/
//    BUF_W/CNT_W constants.
//  - Sub-module cpu2core_cpu0_dct_hold_reg: one-entry valid/ready holding register
//    (load, data, count in; out_valid/out_data/out_count out; hold_free out).
//  - Top: FSM, pack buffer, flush_pend, drop counter.
// TESTING
//  1 Reset, trace_en=1, 15 symbols 2'b01..(k%4) back-to-back, out_ready=1 -> one word,
//    out_count=15, out_data slot k = k%4, out_valid 2 cycles after 15th symbol.
//  2 3 symbols 2'b11 then flush_req -> out_data=30'h3F, out_count=3; flush with count 0 ->
//    no out_valid.
//  3 out_ready=0, 40 continuous symbols -> first word held, second buffer full at 15, 10
//    dropped: drop_count=10, overflow=1; release ready -> both words delivered in order.
//  4 Symbol at dct_count==15 on the transfer edge -> dct_count=1, slot 0 = that symbol.
//  5 5 symbols, test_end_req, out_ready delayed 4 cycles -> test_ending high, partial word
//    count 5, then test_has_ended=1 one cycle after handshake; later symbols ignored.
//  6 reset_n=0 mid-word with out_valid=1 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/cpu2core_cpu0_dct_pkg.sv
// Shared constants and FSM state type for the cpu0 DCT trace capture controller.
package cpu2core_cpu0_dct_pkg;
    localparam int SYM_W  = 2;
    localparam int SLOTS  = 15;
    localparam int BUF_W  = SYM_W * SLOTS;
    localparam int CNT_W  = 4;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ENDING  = 2'd2,
        ENDED   = 2'd3
    } dct_state_e;
endpackage

// File: rtl/cpu2core_cpu0_dct_hold_reg.sv
// One-entry valid/ready holding register between the pack buffer and the trace writer.
module cpu2core_cpu0_dct_hold_reg
    import cpu2core_cpu0_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             hold_free
);
    assign hold_free = !out_valid || out_ready;

    // load is only asserted while hold_free, so it may overwrite a word being handed off
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/cpu2core_cpu0_dct_capture_ctrl.sv
// cpu0 DCT capture: packs 2-bit trace symbols into 30-bit words and sequences end-of-test flush.
module cpu2core_cpu0_dct_capture_ctrl
    import cpu2core_cpu0_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trace_en,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym_data,
    input  logic              flush_req,
    input  logic              test_end_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUF_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              test_ending,
    output logic              test_has_ended,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);
    dct_state_e state, state_n;
    logic       flush_pend, flush_pend_n;
    logic       hold_free, xfer, accept, drop, is_full;
    logic [BUF_W-1:0] buf_n;
    logic [CNT_W-1:0] cnt_n;

    assign is_full = (dct_count == CNT_W'(SLOTS));
    assign xfer    = hold_free && (is_full || (flush_pend && dct_count != '0));
    assign accept  = sym_valid && (state == CAPTURE) && (!is_full || xfer);
    assign drop    = sym_valid && (state == CAPTURE) && is_full && !xfer;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (test_end_req) state_n = ENDING;
                     else if (trace_en) state_n = CAPTURE;
            CAPTURE: if (test_end_req) state_n = ENDING;
                     else if (!trace_en) state_n = IDLE;
            ENDING:  if (dct_count == '0 && !flush_pend && !out_valid) state_n = ENDED;
            ENDED:   state_n = ENDED;
            default: state_n = IDLE;
        endcase
    end

    // A pending flush with nothing buffered is dropped; a new request wins over any clear
    always_comb begin
        flush_pend_n = flush_pend;
        if (xfer || (flush_pend && dct_count == '0))
            flush_pend_n = 1'b0;
        if ((flush_req && state != ENDED) ||
            (test_end_req && (state == IDLE || state == CAPTURE)))
            flush_pend_n = 1'b1;
    end

    always_comb begin
        buf_n = dct_buffer;
        cnt_n = dct_count;
        if (xfer) begin
            buf_n = accept ? BUF_W'(sym_data) : '0;
            cnt_n = accept ? CNT_W'(1) : '0;
        end else if (accept) begin
            buf_n = dct_buffer | (BUF_W'(sym_data) << {dct_count, 1'b0});
            cnt_n = dct_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_n;
            flush_pend <= flush_pend_n;
            dct_buffer <= buf_n;
            dct_count  <= cnt_n;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    assign test_ending    = (state == ENDING);
    assign test_has_ended = (state == ENDED);

    cpu2core_cpu0_dct_hold_reg u_hold (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (xfer),
        .load_data  (dct_buffer),
        .load_count (dct_count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count),
        .hold_free  (hold_free)
    );
endmodule
